// File: rtl/controle_elevador.sv
// controle_elevador: elevator car controller. Latches floor calls, keeps the
// current floor and serves calls in SCAN order (keep going while calls lie
// ahead, otherwise reverse). Motor and door outputs are registered.
//
// state    | meaning
// PARADO   | idle at andar, choosing the next move
// SUBINDO  | travelling up; andar is the floor just left
// DESCENDO | travelling down; andar is the floor just left
// PORTA    | door open at andar for T_PORTA cycles
module controle_elevador #(
  parameter int N_ANDARES = 16,
  parameter int T_VIAGEM  = 8,
  parameter int T_PORTA   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        botao_valido,
  input  logic [3:0]  botao,
  output logic [3:0]  andar,
  output logic        sobe,
  output logic        desce,
  output logic        porta_aberta,
  output logic [15:0] pendentes,
  output logic        ocupado
);

  localparam int T_MAX = (T_VIAGEM > T_PORTA) ? T_VIAGEM : T_PORTA;
  localparam int TW    = $clog2(T_MAX + 1);
  localparam logic [TW-1:0] CARGA_VIAGEM = TW'(T_VIAGEM - 1);
  localparam logic [TW-1:0] CARGA_PORTA  = TW'(T_PORTA - 1);
  localparam logic [3:0]    ULTIMO       = 4'(N_ANDARES - 1);
  localparam logic [15:0]   MASCARA      = 16'((32'd1 << N_ANDARES) - 32'd1);

  typedef enum logic [1:0] {PARADO, SUBINDO, DESCENDO, PORTA} estado_t;

  estado_t        estado_q, estado_d;
  logic [3:0]     andar_q, andar_d;
  logic [15:0]    pend_q, pend_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           dir_q, dir_d;
  logic           sobe_q, desce_q, porta_q;

  logic           chamada_ok;
  logic           chamada_aqui;
  logic           chamada_prox;
  logic [3:0]     prox_andar;
  logic           timer_fim;

  // Direction test shared with the up/down decision: sign of the 5-bit
  // two's-complement difference (floor i - pos).
  function automatic logic acima(input logic [15:0] p, input logic [3:0] pos);
    logic       r;
    logic [4:0] dif;
    r = 1'b0;
    for (int i = 0; i < 16; i++) begin
      dif = 5'(i) - {1'b0, pos};
      if (p[i] && !dif[4] && (dif != 5'd0)) r = 1'b1;
    end
    return r;
  endfunction

  function automatic logic abaixo(input logic [15:0] p, input logic [3:0] pos);
    logic       r;
    logic [4:0] dif;
    r = 1'b0;
    for (int i = 0; i < 16; i++) begin
      dif = 5'(i) - {1'b0, pos};
      if (p[i] && dif[4]) r = 1'b1;
    end
    return r;
  endfunction

  assign chamada_ok   = botao_valido && ({1'b0, botao} < 5'(N_ANDARES));
  assign chamada_aqui = chamada_ok && (botao == andar_q);
  assign chamada_prox = chamada_ok && (botao == prox_andar);
  assign timer_fim    = (timer_q == '0);

  // Floor reached at the end of the current hop, saturated at both ends.
  always_comb begin
    prox_andar = andar_q;
    if (estado_q == SUBINDO) begin
      if (andar_q < ULTIMO) prox_andar = andar_q + 4'd1;
    end else if (estado_q == DESCENDO) begin
      if (andar_q != 4'd0) prox_andar = andar_q - 4'd1;
    end
  end

  // Next-state logic: call latch, SCAN decisions, travel and door timers.
  always_comb begin
    estado_d = estado_q;
    andar_d  = andar_q;
    timer_d  = timer_q;
    dir_d    = dir_q;
    pend_d   = pend_q;
    if (chamada_ok) pend_d[botao] = 1'b1;

    case (estado_q)
      PARADO: begin
        if (pend_q[andar_q] || chamada_aqui) begin
          pend_d[andar_q] = 1'b0;
          estado_d        = PORTA;
          timer_d         = CARGA_PORTA;
        end else if (acima(pend_q, andar_q) && (dir_q || !abaixo(pend_q, andar_q))) begin
          estado_d = SUBINDO;
          dir_d    = 1'b1;
          timer_d  = CARGA_VIAGEM;
        end else if (abaixo(pend_q, andar_q)) begin
          estado_d = DESCENDO;
          dir_d    = 1'b0;
          timer_d  = CARGA_VIAGEM;
        end
      end
      SUBINDO, DESCENDO: begin
        if (timer_fim) begin
          andar_d = prox_andar;
          // A call for the arrival floor in the arrival cycle is absorbed by the stop.
          if (pend_q[prox_andar] || chamada_prox) begin
            pend_d[prox_andar] = 1'b0;
            estado_d           = PORTA;
            timer_d            = CARGA_PORTA;
          end else if ((estado_q == SUBINDO) ? acima(pend_q, prox_andar)
                                             : abaixo(pend_q, prox_andar)) begin
            timer_d = CARGA_VIAGEM;
          end else begin
            estado_d = PARADO;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      PORTA: begin
        if (chamada_aqui) begin
          pend_d[andar_q] = 1'b0;
          timer_d         = CARGA_PORTA;
        end else if (timer_fim) begin
          estado_d = PARADO;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: estado_d = PARADO;
    endcase

    pend_d = pend_d & MASCARA;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= PARADO;
      andar_q  <= 4'd0;
      pend_q   <= 16'd0;
      timer_q  <= '0;
      dir_q    <= 1'b1;
      sobe_q   <= 1'b0;
      desce_q  <= 1'b0;
      porta_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      andar_q  <= andar_d;
      pend_q   <= pend_d;
      timer_q  <= timer_d;
      dir_q    <= dir_d;
      sobe_q   <= (estado_d == SUBINDO);
      desce_q  <= (estado_d == DESCENDO);
      porta_q  <= (estado_d == PORTA);
    end
  end

  assign andar        = andar_q;
  assign sobe         = sobe_q;
  assign desce        = desce_q;
  assign porta_aberta = porta_q;
  assign pendentes    = pend_q;
  assign ocupado      = (estado_q != PARADO) || (pend_q != 16'd0);

endmodule

// File: tb/tb_controle_elevador.sv
// Bench for controle_elevador: directed scenarios plus a randomized run
// against a floor/call-list reference model.
module tb_controle_elevador;

  localparam int NF = 10;
  localparam int TV = 8;
  localparam int TP = 16;

  localparam int MI = 0;  // idle
  localparam int MU = 1;  // going up
  localparam int MD = 2;  // going down
  localparam int MO = 3;  // door open

  logic        clk;
  logic        rst_n;
  logic        botao_valido;
  logic [3:0]  botao;
  logic [3:0]  andar;
  logic        sobe, desce, porta_aberta;
  logic [15:0] pendentes;
  logic        ocupado;

  int total;
  int bad;
  int paradas[$];

  int        m_mode;
  int        m_floor;
  int        m_left;
  bit        m_up;
  bit [15:0] m_calls;

  controle_elevador #(.N_ANDARES(NF), .T_VIAGEM(TV), .T_PORTA(TP)) dut (
    .clk(clk), .rst_n(rst_n), .botao_valido(botao_valido), .botao(botao),
    .andar(andar), .sobe(sobe), .desce(desce), .porta_aberta(porta_aberta),
    .pendentes(pendentes), .ocupado(ocupado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit any_above(input bit [15:0] c, input int f);
    for (int i = f + 1; i < NF; i++) if (c[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit any_below(input bit [15:0] c, input int f);
    for (int i = 0; i < f; i++) if (c[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Reference model: a car with a call list, a floor number and a countdown
  // of cycles left in the current hop or door dwell.
  task automatic model_step(input bit v, input int b);
    bit [15:0] old;
    int nc;
    bit keep;
    old  = m_calls;
    nc   = (v && b < NF) ? b : -1;
    keep = 1'b1;
    case (m_mode)
      MI: begin
        if (old[m_floor] || nc == m_floor) begin
          m_calls[m_floor] = 1'b0;
          keep = (nc != m_floor);
          m_mode = MO;
          m_left = TP;
        end else if (any_above(old, m_floor) && (m_up || !any_below(old, m_floor))) begin
          m_mode = MU; m_up = 1'b1; m_left = TV;
        end else if (any_below(old, m_floor)) begin
          m_mode = MD; m_up = 1'b0; m_left = TV;
        end
      end
      MU, MD: begin
        m_left--;
        if (m_left == 0) begin
          m_floor += (m_mode == MU) ? 1 : -1;
          if (old[m_floor] || nc == m_floor) begin
            m_calls[m_floor] = 1'b0;
            if (nc == m_floor) keep = 1'b0;
            m_mode = MO;
            m_left = TP;
          end else if ((m_mode == MU) ? any_above(old, m_floor) : any_below(old, m_floor)) begin
            m_left = TV;
          end else begin
            m_mode = MI;
          end
        end
      end
      default: begin
        if (nc == m_floor) begin
          m_left = TP;
          keep = 1'b0;
        end else begin
          m_left--;
          if (m_left == 0) m_mode = MI;
        end
      end
    endcase
    if (nc >= 0 && keep) m_calls[nc] = 1'b1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = MI; m_floor = 0; m_left = 0; m_up = 1'b1; m_calls = '0;
    end else begin
      model_step(botao_valido, int'(botao));
    end
  end

  task automatic press(input int f);
    @(negedge clk);
    botao_valido = 1'b1;
    botao = 4'(f);
    @(negedge clk);
    botao_valido = 1'b0;
  endtask

  // Runs until the car is idle, recording each floor where the door opens.
  task automatic observe(input int budget, output bit ok, output bit overlap);
    bit prev;
    paradas.delete();
    prev = porta_aberta;
    ok = 1'b0;
    overlap = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if ((sobe && desce) || (porta_aberta && (sobe || desce))) overlap = 1'b1;
      if (porta_aberta && !prev) paradas.push_back(int'(andar));
      prev = porta_aberta;
      if (!ocupado) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit [23:0] got;
    rst_n = 1'b0; botao_valido = 1'b0; botao = 4'd0;
    #1;
    got = {andar, pendentes, sobe, desce, porta_aberta, ocupado};
    total++;
    if (got !== 24'h0) begin bad++; $display("FAIL reset_asserted got=%h want=000000", got); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    got = {andar, pendentes, sobe, desce, porta_aberta, ocupado};
    total++;
    if (got !== 24'h0) begin bad++; $display("FAIL reset_released got=%h want=000000", got); end
  endtask

  task automatic test_travel();
    @(negedge clk);
    botao_valido = 1'b1; botao = 4'd3;
    @(negedge clk);
    botao_valido = 1'b0;
    total++;
    if (pendentes !== 16'h0008 || sobe !== 1'b0 || ocupado !== 1'b1) begin
      bad++; $display("FAIL travel_latch pend=%h sobe=%b ocup=%b want pend=0008 sobe=0 ocup=1",
                      pendentes, sobe, ocupado);
    end
    @(negedge clk);
    for (int k = 0; k < 24; k++) begin
      total++;
      if (sobe !== 1'b1 || desce !== 1'b0 || porta_aberta !== 1'b0 || andar !== 4'(k / 8)) begin
        bad++; $display("FAIL travel_step k=%0d andar=%0d sobe=%b porta=%b want andar=%0d sobe=1 porta=0",
                        k, andar, sobe, porta_aberta, k / 8);
      end
      @(negedge clk);
    end
    for (int k = 0; k < 16; k++) begin
      total++;
      if (porta_aberta !== 1'b1 || sobe !== 1'b0 || andar !== 4'd3 || pendentes !== 16'h0) begin
        bad++; $display("FAIL travel_door k=%0d porta=%b sobe=%b andar=%0d pend=%h want porta=1 andar=3 pend=0",
                        k, porta_aberta, sobe, andar, pendentes);
      end
      @(negedge clk);
    end
    total++;
    if (porta_aberta !== 1'b0 || ocupado !== 1'b0 || pendentes !== 16'h0) begin
      bad++; $display("FAIL travel_end porta=%b ocup=%b pend=%h want 0 0 0", porta_aberta, ocupado, pendentes);
    end
  endtask

  task automatic test_reset_mid();
    bit [23:0] got;
    press(7);
    repeat (12) @(negedge clk);
    total++;
    if (sobe !== 1'b1) begin bad++; $display("FAIL midreset_moving sobe=%b want=1", sobe); end
    #2 rst_n = 1'b0;
    #1;
    got = {andar, pendentes, sobe, desce, porta_aberta, ocupado};
    total++;
    if (got !== 24'h0) begin bad++; $display("FAIL midreset_outputs got=%h want=000000", got); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_scan();
    bit ok, ov, found;
    press(5);
    observe(400, ok, ov);
    total++;
    if (!ok || andar !== 4'd5) begin bad++; $display("FAIL scan_setup ok=%b andar=%0d want ok=1 andar=5", ok, andar); end
    press(9);
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (sobe) begin found = 1'b1; break; end
      @(negedge clk);
    end
    total++;
    if (!found || andar !== 4'd5) begin bad++; $display("FAIL scan_start sobe=%b andar=%0d want sobe=1 andar=5", found, andar); end
    press(2);
    press(7);
    observe(600, ok, ov);
    total++;
    if (!ok || ov) begin bad++; $display("FAIL scan_run idle=%b overlap=%b want idle=1 overlap=0", ok, ov); end
    total++;
    if (paradas.size() != 3 || paradas[0] != 7 || paradas[1] != 9 || paradas[2] != 2) begin
      bad++; $display("FAIL scan_order got=%p want='{7,9,2}", paradas);
    end
  endtask

  task automatic test_door();
    bit ok, ov;
    press(4);
    observe(400, ok, ov);
    total++;
    if (!ok || andar !== 4'd4) begin bad++; $display("FAIL door_setup ok=%b andar=%0d want ok=1 andar=4", ok, andar); end
    @(negedge clk);
    botao_valido = 1'b1; botao = 4'd4;
    @(negedge clk);
    botao_valido = 1'b0;
    for (int c = 1; c <= 26; c++) begin
      total++;
      if (porta_aberta !== 1'b1 || pendentes !== 16'h0) begin
        bad++; $display("FAIL door_open c=%0d porta=%b pend=%h want porta=1 pend=0", c, porta_aberta, pendentes);
      end
      botao_valido = (c == 10);
      botao = 4'd4;
      @(negedge clk);
    end
    botao_valido = 1'b0;
    total++;
    if (porta_aberta !== 1'b0) begin bad++; $display("FAIL door_close porta=%b want=0", porta_aberta); end
  endtask

  task automatic test_ignore();
    bit ok, ov;
    @(negedge clk);
    botao_valido = 1'b1; botao = 4'd12;
    @(negedge clk);
    botao = 4'd15;
    @(negedge clk);
    botao_valido = 1'b0;
    for (int c = 0; c < 4; c++) begin
      total++;
      if (pendentes !== 16'h0 || ocupado !== 1'b0 || sobe !== 1'b0 || desce !== 1'b0) begin
        bad++; $display("FAIL ignore_high c=%0d pend=%h ocup=%b sobe=%b desce=%b want all 0",
                        c, pendentes, ocupado, sobe, desce);
      end
      @(negedge clk);
    end
    botao_valido = 1'b1; botao = 4'd6;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      botao_valido = (c == 17);
    end
    @(negedge clk);
    botao_valido = 1'b0;
    total++;
    if (andar !== 4'd6 || porta_aberta !== 1'b1 || pendentes !== 16'h0) begin
      bad++; $display("FAIL tie_arrival andar=%0d porta=%b pend=%h want andar=6 porta=1 pend=0",
                      andar, porta_aberta, pendentes);
    end
    observe(100, ok, ov);
    press(6);
    total++;
    if (!ok || porta_aberta !== 1'b1 || pendentes !== 16'h0) begin
      bad++; $display("FAIL idle_same_floor idle=%b porta=%b pend=%h want 1 1 0", ok, porta_aberta, pendentes);
    end
    observe(100, ok, ov);
  endtask

  task automatic test_dir();
    bit ok, ov, found;
    press(1);
    observe(400, ok, ov);
    total++;
    if (!ok || andar !== 4'd1) begin bad++; $display("FAIL dir_setup ok=%b andar=%0d want ok=1 andar=1", ok, andar); end
    press(5);
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (porta_aberta) begin found = 1'b1; break; end
      @(negedge clk);
    end
    total++;
    if (!found || andar !== 4'd5) begin bad++; $display("FAIL dir_arrive door=%b andar=%0d want door=1 andar=5", found, andar); end
    press(2);
    press(8);
    observe(600, ok, ov);
    total++;
    if (!ok || ov || paradas.size() != 2 || paradas[0] != 8 || paradas[1] != 2) begin
      bad++; $display("FAIL dir_order idle=%b overlap=%b got=%p want='{8,2}", ok, ov, paradas);
    end
  endtask

  task automatic test_random();
    bit [23:0] got, want;
    @(negedge clk);
    rst_n = 1'b0; botao_valido = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      got  = {andar, pendentes, sobe, desce, porta_aberta, ocupado};
      want = {4'(m_floor), m_calls, (m_mode == MU), (m_mode == MD), (m_mode == MO),
              ((m_mode != MI) || (m_calls != 16'h0))};
      total++;
      if (got !== want) begin
        bad++; $display("FAIL random_model c=%0d got=%h want=%h", c, got, want);
      end
      total++;
      if (int'(sobe) + int'(desce) + int'(porta_aberta) > 1) begin
        bad++; $display("FAIL random_exclusive c=%0d sobe=%b desce=%b porta=%b want at most one",
                        c, sobe, desce, porta_aberta);
      end
      botao_valido = ($urandom_range(0, 11) == 0);
      botao = 4'($urandom_range(0, 15));
    end
    botao_valido = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    botao_valido = 1'b0;
    botao = 4'd0;
    test_reset();
    test_travel();
    test_reset_mid();
    test_scan();
    test_door();
    test_ignore();
    test_dir();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
